// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder: packs a 32-bit big-endian word stream into padded 512-bit blocks.
// Define SHA256_PAD_INDEX_EN to add the BUSY state driving enable/w_vector_index/w_index_complete.
module sha256_msg_padder #(
  parameter int MAX_LEN_BITS = 64
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [31:0]  in_data,
  input  logic         in_last,
  input  logic [2:0]   in_bytes,
  output logic         block_valid,
  input  logic         block_ready,
  output logic         block_last,
  output logic [511:0] message_vector
`ifdef SHA256_PAD_INDEX_EN
  ,
  output logic         enable,
  output logic [5:0]   w_vector_index,
  output logic         w_index_complete
`endif
);

  typedef enum logic [1:0] {FILL, EMIT, BUSY} state_t;

  state_t                  state_reg, state_next;
  logic                    armed_reg;
  logic [31:0]             slot_reg [0:15];
  logic [31:0]             fill_word [0:15];
  logic [31:0]             extra_word [0:15];
  logic [3:0]              wc_reg;
  logic [MAX_LEN_BITS-1:0] len_reg;
  logic [MAX_LEN_BITS-1:0] len_sum;
  logic                    pend_len_reg, pend_marker_reg, last_reg;

  logic        accept, handshake, full_word, fits, reload, busy_done;
  logic [5:0]  add_bits;
  logic [4:0]  k;
  logic [31:0] data_word;
  logic [63:0] len_new64, len_cur64;

  assign accept    = in_valid && in_ready;
  assign handshake = block_valid && block_ready;
  // Out-of-range byte counts on the final word behave as a full word.
  assign full_word = !(in_bytes == 3'd1 || in_bytes == 3'd2 || in_bytes == 3'd3);
  assign add_bits  = (in_last && !full_word) ? {in_bytes, 3'b000} : 6'd32;
  assign len_sum   = len_reg + MAX_LEN_BITS'(add_bits);
  assign len_new64 = 64'(len_sum);
  assign len_cur64 = 64'(len_reg);
  assign k         = {1'b0, wc_reg} + 5'd1 + {4'd0, full_word};
  assign fits      = (k <= 5'd14);

  always_comb begin
    data_word = in_data;
    if (in_last) begin
      case (in_bytes)
        3'd1:    data_word = {in_data[31:24], 24'h80_0000};
        3'd2:    data_word = {in_data[31:16], 16'h8000};
        3'd3:    data_word = {in_data[31:8], 8'h80};
        default: data_word = in_data;
      endcase
    end
  end

  for (genvar gi = 0; gi < 16; gi++) begin : g_slot
    localparam logic [4:0] IDX = 5'(gi);
    // Slots past the write pointer are rewritten each cycle so stale data never leaks.
    always_comb begin
      if (IDX == {1'b0, wc_reg})                 fill_word[gi] = data_word;
      else if (IDX < {1'b0, wc_reg})             fill_word[gi] = slot_reg[gi];
      else if (in_last && IDX < k)               fill_word[gi] = 32'h8000_0000;
      else if (in_last && fits && IDX == 5'd14)  fill_word[gi] = len_new64[63:32];
      else if (in_last && fits && IDX == 5'd15)  fill_word[gi] = len_new64[31:0];
      else                                       fill_word[gi] = '0;
    end
    if (gi == 0) begin : g_marker
      assign extra_word[gi] = pend_marker_reg ? 32'h8000_0000 : 32'h0;
    end else if (gi == 14) begin : g_len_hi
      assign extra_word[gi] = len_cur64[63:32];
    end else if (gi == 15) begin : g_len_lo
      assign extra_word[gi] = len_cur64[31:0];
    end else begin : g_zero
      assign extra_word[gi] = '0;
    end
    assign message_vector[511-32*gi -: 32] = slot_reg[gi];
  end

`ifdef SHA256_PAD_INDEX_EN
  logic [6:0] cnt_reg;
  assign busy_done = (state_reg == BUSY) && (cnt_reg == 7'd64);
  assign reload    = pend_len_reg && busy_done;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) cnt_reg <= '0;
    else if (state_reg == BUSY && !busy_done) cnt_reg <= cnt_reg + 7'd1;
    else cnt_reg <= '0;
  end
`else
  assign busy_done = 1'b0;
  assign reload    = pend_len_reg && handshake;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_reg <= FILL;
      armed_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      armed_reg <= 1'b1;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      FILL: if (accept && (in_last || wc_reg == 4'd15)) state_next = EMIT;
`ifdef SHA256_PAD_INDEX_EN
      EMIT: if (handshake) state_next = BUSY;
`else
      EMIT: if (handshake) state_next = pend_len_reg ? EMIT : FILL;
`endif
      BUSY: if (busy_done) state_next = pend_len_reg ? EMIT : FILL;
      default: state_next = FILL;
    endcase
  end

  always_comb begin
    in_ready    = armed_reg && (state_reg == FILL);
    block_valid = (state_reg == EMIT);
`ifdef SHA256_PAD_INDEX_EN
    enable           = (state_reg == BUSY);
    w_index_complete = busy_done;
    w_vector_index   = '0;
    if (state_reg == BUSY) w_vector_index = busy_done ? 6'd63 : cnt_reg[5:0];
`endif
  end

  assign block_last = last_reg;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 16; i++) slot_reg[i] <= '0;
      wc_reg          <= '0;
      len_reg         <= '0;
      pend_len_reg    <= 1'b0;
      pend_marker_reg <= 1'b0;
      last_reg        <= 1'b0;
    end else begin
      if (accept) begin
        for (int i = 0; i < 16; i++) slot_reg[i] <= fill_word[i];
        wc_reg  <= wc_reg + 4'd1;
        len_reg <= len_sum;
        if (in_last) begin
          last_reg        <= fits;
          pend_len_reg    <= !fits;
          pend_marker_reg <= (wc_reg == 4'd15) && full_word;
        end else begin
          last_reg <= 1'b0;
        end
      end
      if (handshake) begin
        wc_reg   <= '0;
        last_reg <= 1'b0;
        if (last_reg) len_reg <= '0;
      end
      // The trailing length-only block overrides the handshake bookkeeping above.
      if (reload) begin
        for (int i = 0; i < 16; i++) slot_reg[i] <= extra_word[i];
        last_reg        <= 1'b1;
        pend_len_reg    <= 1'b0;
        pend_marker_reg <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Bench for sha256_msg_padder: random byte messages compared block-by-block with a FIPS 180-4 padding model.
`timescale 1ns/1ps
module tb_sha256_msg_padder;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [31:0]  in_data = '0;
  logic         in_last = 1'b0;
  logic [2:0]   in_bytes = '0;
  logic         block_valid;
  logic         block_ready = 1'b0;
  logic         block_last;
  logic [511:0] message_vector;
`ifdef SHA256_PAD_INDEX_EN
  logic         enable;
  logic [5:0]   w_vector_index;
  logic         w_index_complete;
`endif

  int errors = 0;
  int checks = 0;
  logic [7:0]   msg[$];
  logic [511:0] exp_blocks[$];
  bit           exp_last[$];

  sha256_msg_padder #(.MAX_LEN_BITS(64)) dut (
    .clock(clock),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .in_bytes(in_bytes),
    .block_valid(block_valid),
    .block_ready(block_ready),
    .block_last(block_last),
    .message_vector(message_vector)
`ifdef SHA256_PAD_INDEX_EN
    ,
    .enable(enable),
    .w_vector_index(w_vector_index),
    .w_index_complete(w_index_complete)
`endif
  );

  always #5 clock = ~clock;

  task automatic check_value(input string tag, input logic [511:0] got, input logic [511:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: append 0x80, zero-fill to 56 mod 64 bytes, append 64-bit bit length, cut into 64-byte blocks.
  task automatic build_model();
    logic [7:0]   p[$];
    logic [63:0]  bits;
    logic [511:0] v;
    int           nblk;
    p = msg;
    bits = 64'(msg.size()) * 64'd8;
    p.push_back(8'h80);
    while (p.size() % 64 != 56) p.push_back(8'h00);
    for (int i = 7; i >= 0; i--) p.push_back(bits[8*i +: 8]);
    exp_blocks.delete();
    exp_last.delete();
    nblk = p.size() / 64;
    for (int b = 0; b < nblk; b++) begin
      for (int j = 0; j < 64; j++) v[511-8*j -: 8] = p[b*64+j];
      exp_blocks.push_back(v);
      exp_last.push_back(b == nblk - 1);
    end
  endtask

  task automatic make_msg(input int n);
    msg.delete();
    for (int i = 0; i < n; i++) msg.push_back(8'($urandom));
  endtask

  task automatic send_msg(input int stop_after);
    int nw;
    nw = (msg.size() + 3) / 4;
    for (int w = 0; w < nw; w++) begin
      logic [31:0] d;
      logic        lst;
      logic [2:0]  nb;
      int          rem;
      int          waited;
      int          v;
      if (stop_after >= 0 && w == stop_after) break;
      repeat ($urandom_range(0, 2)) @(negedge clock);
      d = $urandom;
      rem = msg.size() - 4*w;
      for (int b = 0; b < 4 && b < rem; b++) d[31-8*b -: 8] = msg[4*w+b];
      lst = (w == nw - 1);
      nb = 3'($urandom_range(0, 7));
      if (lst) begin
        v = $urandom_range(0, 4);
        nb = (rem >= 4) ? ((v == 0) ? 3'd0 : 3'(v + 3)) : 3'(rem);
      end
      in_valid = 1'b1;
      in_data  = d;
      in_last  = lst;
      in_bytes = nb;
      waited = 0;
      while (!in_ready && waited < 400) begin
        @(negedge clock);
        waited++;
      end
      if (!in_ready) begin
        check_value("in_ready_timeout", in_ready, 1);
        in_valid = 1'b0;
        return;
      end
      @(posedge clock);
      @(negedge clock);
      in_valid = 1'b0;
      if (lst || (w % 16 == 15)) check_value("valid_latency", block_valid, 1);
    end
  endtask

`ifdef SHA256_PAD_INDEX_EN
  task automatic monitor_busy();
    for (int c = 0; c <= 64; c++) begin
      check_value("busy_enable", enable, 1);
      check_value("busy_index", w_vector_index, (c > 63) ? 63 : c);
      check_value("busy_complete", w_index_complete, c == 64);
      check_value("busy_in_ready", in_ready, 0);
      @(negedge clock);
    end
    check_value("idle_enable", enable, 0);
    check_value("idle_index", w_vector_index, 0);
    check_value("resume", in_ready | block_valid, 1);
  endtask
`endif

  task automatic recv_blocks(input int hold);
    int got;
    int guard;
    int held;
    logic [511:0] snap;
    got = 0;
    guard = 0;
    held = 0;
    snap = '0;
    while (got < exp_blocks.size() && guard < 4000) begin
      guard++;
      if (block_valid && held < hold) begin
        block_ready = 1'b0;
        if (held > 0) begin
          check_value("hold_vector", message_vector, snap);
          check_value("hold_in_ready", in_ready, 0);
        end
        snap = message_vector;
        held++;
        @(negedge clock);
      end else begin
        block_ready = ($urandom_range(0, 3) != 0);
        if (block_valid && block_ready) begin
          check_value($sformatf("block%0d_vector", got), message_vector, exp_blocks[got]);
          check_value($sformatf("block%0d_last", got), block_last, exp_last[got]);
          got++;
          @(posedge clock);
          @(negedge clock);
          block_ready = 1'b0;
`ifdef SHA256_PAD_INDEX_EN
          monitor_busy();
`endif
        end else begin
          @(negedge clock);
        end
      end
    end
    block_ready = 1'b0;
    if (got < exp_blocks.size()) check_value("block_timeout", got, exp_blocks.size());
  endtask

  task automatic run_message(input int hold);
    build_model();
    fork
      send_msg(-1);
      recv_blocks(hold);
    join
  endtask

  task automatic check_reset_outputs(input string tag);
    check_value({tag, "_in_ready"}, in_ready, 0);
    check_value({tag, "_block_valid"}, block_valid, 0);
    check_value({tag, "_block_last"}, block_last, 0);
    check_value({tag, "_vector"}, message_vector, 0);
`ifdef SHA256_PAD_INDEX_EN
    check_value({tag, "_enable"}, enable, 0);
    check_value({tag, "_index"}, w_vector_index, 0);
    check_value({tag, "_complete"}, w_index_complete, 0);
`endif
  endtask

  task automatic load_abc();
    msg.delete();
    msg.push_back(8'h61);
    msg.push_back(8'h62);
    msg.push_back(8'h63);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    #2;
    check_reset_outputs("reset");
    @(negedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
    check_value("ready_after_reset", in_ready, 1);
    check_value("idle_block_valid", block_valid, 0);

    load_abc();
    run_message(0);
    make_msg(56);
    run_message(0);
    make_msg(64);
    run_message(0);
    make_msg(48);
    msg.push_back(8'hAA);
    run_message(0);
    make_msg(20);
    run_message(20);

    // Abort a message part-way through the first block, then replay "abc".
    make_msg(40);
    send_msg(7);
    #2 reset = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    @(negedge clock);
    #2 reset = 1'b1;
    @(negedge clock);
    load_abc();
    run_message(0);

    for (int n = 52; n <= 68; n++) begin
      make_msg(n);
      run_message(0);
    end
    for (int r = 0; r < 25; r++) begin
      make_msg($urandom_range(1, 150));
      run_message($urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/sha256_msg_padder.md
# sha256_msg_padder

Front end of the SHA-256 datapath and the producer side of the message-schedule interface. Accepts a byte-aligned message as a stream of 32-bit big-endian words, applies FIPS 180-4 padding (0x80 marker, zero fill, 64-bit big-endian bit length), and issues 512-bit blocks over a valid/ready handshake in the layout the W-schedule expansion stage consumes. Optionally generates that stage's `enable` / `w_vector_index` / `w_index_complete` sequencing.

## Interface
- `MAX_LEN_BITS`, 64: width of the internal bit-length counter; the length field is always 64 bits, zero-extended.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  input word valid.
- `in_ready`  out  1  padder accepts a word when `in_valid && in_ready`.
- `in_data`  in  32  message word; first byte in [31:24].
- `in_last`  in  1  final word of message.
- `in_bytes`  in  3  valid bytes in final word, 1..4, left-justified; ignored unless `in_last`.
- `block_valid`  out  1  `message_vector` holds a complete block.
- `block_ready`  in  1  downstream accepts the block.
- `block_last`  out  1  block is the final block of the message.
- `message_vector`  out  512  block; word i at [511-32i -: 32].
- `enable`, `w_vector_index` [5:0], `w_index_complete`  out  present only with `SHA256_PAD_INDEX_EN`.

## Operation
- States: FILL, EMIT, BUSY (BUSY only with macro).
- FILL: `in_ready`=1. Accepted word written to word slot `wc` (0..15); `wc`++; length += 32, or 8*`in_bytes` on last word.
- Non-last word filling slot 15 -> EMIT, `block_last`=0.
- Last word, in_bytes<4: bytes beyond `in_bytes` replaced by 0x80 then zeros; k=wc+1 words used. In_bytes=4: 0x80000000 in slot wc+1 if wc<15; k=wc+2.
- k<=14: slots k..13 zeroed, slots 14/15 = length[63:32]/[31:0]; EMIT with `block_last`=1.
- k>14: remaining slots zeroed, EMIT with `block_last`=0, `pend_len`=1 (and `pend_marker`=1 if wc=15, in_bytes=4).
- EMIT handshake (`block_valid && block_ready`): if `pend_len`, buffer reloaded with extra block (slot 0 = 0x80000000 if `pend_marker`, else 0; zeros; length in 14/15), stay EMIT, `block_last`=1. Else go FILL (or BUSY), `wc`=0; after a `block_last` handshake length clears to 0.
- Empty messages unsupported; length overflow beyond 2^64 unchecked.
- `in_bytes` of 0, 5..7 on last word treated as 4.

## Timing
- Reset: `in_ready`=0 during reset, 1 the first cycle after release; `block_valid`=0, `block_last`=0, `message_vector`=0, `enable`=0, `w_vector_index`=0, `w_index_complete`=0; state FILL, `wc`=0, length=0.
- Word accepted at edge t that completes a block -> `block_valid`=1 from cycle t+1; `in_ready`=0 while in EMIT.
- `message_vector` stable while `block_valid`=1 and until next FILL write.
- Extra length block valid the cycle after the first block's handshake.
- Reset asserted mid-message or mid-block: all state discarded immediately; no partial block issued.

## Configuration
- `SHA256_PAD_INDEX_EN` defined: after each block handshake enter BUSY; cycle after handshake `enable`=1, `w_vector_index`=0, +1 per cycle to 63; the cycle after index 63, `w_index_complete`=1 for one cycle with `enable`=1 and index held at 63; next cycle `enable`=0, index=0, return to FILL (or EMIT for pending extra block). `in_ready`=0 and `message_vector` held throughout BUSY. 66 cycles from handshake to next `in_ready` or `block_valid`.
- Undefined: ports absent, no BUSY; EMIT -> FILL directly.

## Test plan
- "abc": one word 0x61626300, in_bytes=3, last -> one block, word0=0x61626380, words1..14=0, word15=0x00000018, `block_last`=1.
- 14 full words, last on 14th (in_bytes=4) -> word14=0x80000000 needs slot 14: k=15>14 -> block 1 words 0..13 data, 14=0x80000000, 15=0; block 2 zeros, word15=0x000001C0, `block_last`=1 only on block 2.
- 16 full words, last -> block 1 all data `block_last`=0; block 2 word0=0x80000000, word15=0x00000200.
- 13 words, last in_bytes=1 value 0xAA000000 -> word12=0xAA800000, word15=0x00000188, single block.
- Hold `block_ready`=0 20 cycles -> `block_valid` and `message_vector` stable, `in_ready`=0; release -> handshake, next message accepted.
- Reset low at wc=7 -> outputs return to reset values asynchronously; following "abc" yields exact first-scenario block. With macro: index 0..63 then one `w_index_complete` pulse, `in_ready` high 66 cycles after handshake.
